// File: rtl/bsg_mux_one_hot_pkg.sv
// Shared definitions for the buffered one-hot mux: buffer state encoding
// and the select legality check.
package bsg_mux_one_hot_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    // Widest select the legality check covers; narrower selects are zero-extended.
    localparam int max_els_lp = 64;

    // Exactly-one-bit test: "any" is the OR-reduce of the bits, "multi" ORs
    // together every bit ANDed with the OR of the bits below it.
    function automatic logic is_one_hot(input logic [max_els_lp-1:0] sel);
        logic any;
        logic multi;
        any   = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < max_els_lp; i++) begin
            multi = multi | (any & sel[i]);
            any   = any | sel[i];
        end
        return any & ~multi;
    endfunction

endpackage

// File: rtl/bsg_mux_one_hot_buffered_if.sv
// Valid/ready bus of the buffered one-hot mux; the mux itself is the slave.
interface bsg_mux_one_hot_buffered_if #(
    parameter int width_p         = 28,
    parameter int els_p           = 2,
    parameter int err_cnt_width_p = 8
);
    logic                       v_i;
    logic                       ready_o;
    logic [els_p*width_p-1:0]   data_i;
    logic [els_p-1:0]           sel_one_hot_i;
    logic                       v_o;
    logic [width_p-1:0]         data_o;
    logic                       ready_i;
    logic                       err_o;
    logic [err_cnt_width_p-1:0] err_cnt_o;

    modport slave (
        input  v_i, data_i, sel_one_hot_i, ready_i,
        output ready_o, v_o, data_o, err_o, err_cnt_o
    );

    modport master (
        output v_i, data_i, sel_one_hot_i, ready_i,
        input  ready_o, v_o, data_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/bsg_mux_one_hot.sv
// Combinational mask-and-OR one-hot mux; element k is data_i[k*width_p +: width_p].
module bsg_mux_one_hot #(
    parameter int width_p = 28,
    parameter int els_p   = 2
) (
    input  logic [els_p*width_p-1:0] data_i,
    input  logic [els_p-1:0]         sel_one_hot_i,
    output logic [width_p-1:0]       data_o
);

    always_comb begin
        data_o = '0;
        for (int k = 0; k < els_p; k++) begin
            data_o = data_o | (data_i[k*width_p +: width_p] & {width_p{sel_one_hot_i[k]}});
        end
    end

endmodule

// File: rtl/bsg_mux_one_hot_buffered.sv
// Registered one-hot mux with a two-entry skid buffer; illegal selects are
// dropped and tallied in a sticky flag and a saturating counter.
module bsg_mux_one_hot_buffered
    import bsg_mux_one_hot_pkg::*;
#(
    parameter int width_p         = 28,
    parameter int els_p           = 2,
    parameter int err_cnt_width_p = 8
) (
    input logic                      clk_i,
    input logic                      reset_n_i,
    bsg_mux_one_hot_buffered_if.slave bus
);

    localparam logic [1:0] ST_EMPTY = EMPTY;
    localparam logic [1:0] ST_ONE   = ONE;
    localparam logic [1:0] ST_TWO   = TWO;

    logic [1:0]                 state_q, state_d;
    logic [width_p-1:0]         main_q, main_d;
    logic [width_p-1:0]         skid_q, skid_d;
    logic                       err_q, err_d;
    logic [err_cnt_width_p-1:0] err_cnt_q, err_cnt_d;

    logic [width_p-1:0]    mux_word;
    logic [max_els_lp-1:0] sel_ext;
    logic                  sel_legal;
    logic                  in_fire, out_fire, legal_fire, illegal_fire;

    bsg_mux_one_hot #(
        .width_p (width_p),
        .els_p   (els_p)
    ) mux (
        .data_i        (bus.data_i),
        .sel_one_hot_i (bus.sel_one_hot_i),
        .data_o        (mux_word)
    );

    assign sel_ext      = max_els_lp'(bus.sel_one_hot_i);
    assign sel_legal    = is_one_hot(sel_ext);
    assign in_fire      = bus.v_i & bus.ready_o;
    assign out_fire     = bus.v_o & bus.ready_i;
    assign legal_fire   = in_fire & sel_legal;
    assign illegal_fire = in_fire & ~sel_legal;

    // ready_o decodes registered state only, so no ready_i -> ready_o path exists.
    assign bus.ready_o   = (state_q == ST_EMPTY) || (state_q == ST_ONE);
    assign bus.v_o       = (state_q == ST_ONE) || (state_q == ST_TWO);
    assign bus.data_o    = main_q;
    assign bus.err_o     = err_q;
    assign bus.err_cnt_o = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (legal_fire) begin
                    main_d  = mux_word;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (legal_fire && out_fire) begin
                    main_d = mux_word;
                end else if (legal_fire) begin
                    skid_d  = mux_word;
                    state_d = ST_TWO;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (illegal_fire) begin
            err_d = 1'b1;
            if (~&err_cnt_q) begin
                err_cnt_d = err_cnt_q + err_cnt_width_p'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_bsg_mux_one_hot_buffered.sv
// Bench for bsg_mux_one_hot_buffered: a 28x2 and a 64x4 instance, each
// checked every cycle against a queue-based model, plus pinned literal values.
module tb_bsg_mux_one_hot_buffered;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    logic [63:0] mq [2][$];
    int          merr [2];

    bsg_mux_one_hot_buffered_if #(.width_p(28), .els_p(2), .err_cnt_width_p(8)) bus_a ();
    bsg_mux_one_hot_buffered_if #(.width_p(64), .els_p(4), .err_cnt_width_p(8)) bus_b ();

    bsg_mux_one_hot_buffered #(.width_p(28), .els_p(2), .err_cnt_width_p(8)) dut_a (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus_a)
    );

    bsg_mux_one_hot_buffered #(.width_p(64), .els_p(4), .err_cnt_width_p(8)) dut_b (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int id, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", id, nm, act, exp, $time);
        end
    endtask

    // Model: the buffer is a queue of at most two words; an input is taken
    // whenever fewer than two words are held, the head leaves when ready_i is high.
    task automatic model_cycle(input int id, input int w, input int els,
                               input logic v_i, input logic [255:0] data,
                               input logic [3:0] sel, input logic ready_i,
                               input logic dut_ro, input logic dut_vo,
                               input logic [63:0] dut_data, input logic dut_err,
                               input logic [7:0] dut_cnt);
        int          n;
        int          idx;
        logic [63:0] mask;
        logic [63:0] word;
        n = mq[id].size();
        chk(id, "ready_o", 64'(dut_ro), 64'(n < 2));
        chk(id, "v_o", 64'(dut_vo), 64'(n > 0));
        if (n > 0) chk(id, "data_o", dut_data, mq[id][0]);
        chk(id, "err_o", 64'(dut_err), 64'(merr[id] > 0));
        chk(id, "err_cnt_o", 64'(dut_cnt), 64'(merr[id]));

        if (n > 0 && ready_i) void'(mq[id].pop_front());
        if (v_i && n < 2) begin
            if ($countones(sel) == 1) begin
                idx = 0;
                for (int k = 0; k < els; k++) if (sel[k]) idx = k;
                mask = (w == 64) ? '1 : ((64'h1 << w) - 64'h1);
                word = 64'(data >> (idx * w)) & mask;
                mq[id].push_back(word);
            end else if (merr[id] < 255) begin
                merr[id]++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                merr[i] = 0;
            end
        end else begin
            model_cycle(0, 28, 2, bus_a.v_i, 256'(bus_a.data_i), 4'(bus_a.sel_one_hot_i),
                        bus_a.ready_i, bus_a.ready_o, bus_a.v_o, 64'(bus_a.data_o),
                        bus_a.err_o, bus_a.err_cnt_o);
            model_cycle(1, 64, 4, bus_b.v_i, 256'(bus_b.data_i), bus_b.sel_one_hot_i,
                        bus_b.ready_i, bus_b.ready_o, bus_b.v_o, bus_b.data_o,
                        bus_b.err_o, bus_b.err_cnt_o);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] sel, input logic [27:0] e0,
                           input logic [27:0] e1, input logic rdy);
        bus_a.v_i           = v;
        bus_a.sel_one_hot_i = sel;
        bus_a.data_i        = {e1, e0};
        bus_a.ready_i       = rdy;
    endtask

    task automatic rand_drive();
        logic [3:0] sb;
        logic [1:0] sa;
        bus_a.v_i     = ($urandom_range(0, 3) != 0);
        bus_a.ready_i = $urandom_range(0, 1) == 1;
        bus_a.data_i  = 56'({$urandom, $urandom});
        sa = ($urandom_range(0, 9) < 8) ? 2'(1 << $urandom_range(0, 1)) : 2'($urandom);
        bus_a.sel_one_hot_i = sa;
        bus_b.v_i     = ($urandom_range(0, 3) != 0);
        bus_b.ready_i = $urandom_range(0, 1) == 1;
        bus_b.data_i  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        sb = ($urandom_range(0, 9) < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
        bus_b.sel_one_hot_i = sb;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drive_a(1'b0, 2'b00, 28'h0, 28'h0, 1'b0);
        bus_b.v_i = 1'b0; bus_b.ready_i = 1'b0; bus_b.data_i = '0; bus_b.sel_one_hot_i = '0;
        repeat (3) step();
        chk(0, "reset ready_o", 64'(bus_a.ready_o), 64'd1);
        chk(0, "reset v_o", 64'(bus_a.v_o), 64'd0);
        chk(0, "reset data_o", 64'(bus_a.data_o), 64'd0);
        chk(0, "reset err_cnt_o", 64'(bus_a.err_cnt_o), 64'd0);
        #2 reset_n = 1'b1;

        // Single legal transfers through dut A.
        step();
        drive_a(1'b1, 2'b01, 28'h0ABCDEF, 28'h1234567, 1'b1);
        step();
        chk(0, "sel01 v_o", 64'(bus_a.v_o), 64'd1);
        chk(0, "sel01 data_o", 64'(bus_a.data_o), 64'h0ABCDEF);
        drive_a(1'b1, 2'b10, 28'h0ABCDEF, 28'h1234567, 1'b1);
        step();
        chk(0, "sel10 data_o", 64'(bus_a.data_o), 64'h1234567);
        drive_a(1'b0, 2'b00, 28'h0, 28'h0, 1'b1);
        step();

        // Fill the buffer with ready_i low, then drain.
        drive_a(1'b1, 2'b01, 28'h0000111, 28'h0, 1'b0);
        step();
        drive_a(1'b1, 2'b10, 28'h0, 28'h0000222, 1'b0);
        step();
        chk(0, "full ready_o", 64'(bus_a.ready_o), 64'd0);
        drive_a(1'b1, 2'b01, 28'h0000333, 28'h0, 1'b0);
        step();
        chk(0, "full head", 64'(bus_a.data_o), 64'h111);
        drive_a(1'b0, 2'b00, 28'h0, 28'h0, 1'b1);
        step();
        chk(0, "drain ready_o", 64'(bus_a.ready_o), 64'd1);
        chk(0, "drain second", 64'(bus_a.data_o), 64'h222);
        step();
        chk(0, "drained v_o", 64'(bus_a.v_o), 64'd0);

        // Illegal selects: dropped and counted.
        drive_a(1'b1, 2'b00, 28'h5, 28'h6, 1'b1);
        step();
        drive_a(1'b1, 2'b11, 28'h5, 28'h6, 1'b1);
        step();
        drive_a(1'b0, 2'b00, 28'h0, 28'h0, 1'b1);
        chk(0, "illegal v_o", 64'(bus_a.v_o), 64'd0);
        chk(0, "illegal err_o", 64'(bus_a.err_o), 64'd1);
        chk(0, "illegal err_cnt_o", 64'(bus_a.err_cnt_o), 64'd2);

        for (int i = 0; i < 300; i++) begin
            drive_a(1'b1, 2'(i % 2 == 0 ? 2'b00 : 2'b11), 28'h7, 28'h8, 1'b1);
            step();
        end
        drive_a(1'b0, 2'b00, 28'h0, 28'h0, 1'b1);
        step();
        chk(0, "saturated err_cnt_o", 64'(bus_a.err_cnt_o), 64'hFF);

        // Randomized streaming on both instances.
        for (int i = 0; i < 3000; i++) begin
            rand_drive();
            step();
        end
        drive_a(1'b0, 2'b00, 28'h0, 28'h0, 1'b1);
        bus_b.v_i = 1'b0; bus_b.ready_i = 1'b1;
        repeat (4) step();

        // Reach TWO on both, then reset asynchronously mid-cycle.
        drive_a(1'b1, 2'b01, 28'h0DEAD01, 28'h0, 1'b0);
        bus_b.v_i = 1'b1; bus_b.ready_i = 1'b0; bus_b.sel_one_hot_i = 4'b0100;
        bus_b.data_i = {64'h4, 64'h3, 64'h2, 64'h1};
        step();
        drive_a(1'b1, 2'b10, 28'h0, 28'h0DEAD02, 1'b0);
        bus_b.sel_one_hot_i = 4'b1000;
        step();
        chk(0, "two ready_o", 64'(bus_a.ready_o), 64'd0);
        chk(1, "two ready_o", 64'(bus_b.ready_o), 64'd0);
        drive_a(1'b0, 2'b00, 28'h0, 28'h0, 1'b0);
        bus_b.v_i = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk(0, "async rst v_o", 64'(bus_a.v_o), 64'd0);
        chk(0, "async rst data_o", 64'(bus_a.data_o), 64'd0);
        chk(0, "async rst ready_o", 64'(bus_a.ready_o), 64'd1);
        chk(1, "async rst v_o", 64'(bus_b.v_o), 64'd0);
        chk(1, "async rst data_o", bus_b.data_o, 64'd0);
        chk(1, "async rst err_cnt_o", 64'(bus_b.err_cnt_o), 64'd0);
        repeat (2) step();
        #2 reset_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            rand_drive();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
